rc4_xor_stream: RTL and testbench
=================================

Name: rc4_xor_stream

Overview:
- Downstream consumer of the RC4 keystream generator. Takes keystream bytes over a valid/ready interface and buffers them in a small FIFO.
- XORs each buffered keystream byte with one plaintext byte per handshake and emits ciphertext, or plaintext when decrypting, on a registered valid/ready output.
- Frames a message of msg_len bytes and can discard the first DROP_N keystream bytes (RC4-drop[n]).

Parameters:
- KS_DEPTH, 8, keystream FIFO depth in bytes; power of 2, minimum 2.
- DROP_N, 0, keystream bytes discarded at the start of each frame; range 0..1023.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
- msg_len  in  16  frame length in bytes; sampled when start is accepted
- ks_valid  in  1  keystream byte available
- ks_data  in  8  keystream byte
- ks_ready  out  1  keystream byte accepted this cycle when ks_valid&&ks_ready
- pt_valid  in  1  plaintext byte available
- pt_data  in  8  plaintext byte
- pt_ready  out  1  plaintext byte accepted this cycle when pt_valid&&pt_ready
- ct_valid  out  1  output byte valid
- ct_data  out  8  pt_data XOR keystream byte
- ct_last  out  1  marks the final byte of the frame; qualified by ct_valid
- ct_ready  in  1  downstream accepts when ct_valid&&ct_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a frame completes
- ks_level  out  clog2(KS_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides all other activity, including mid-frame:
  - state=IDLE; FIFO pointers and ks_level=0; drop and remaining counters=0.
  - ct_valid=0, ct_data=0, ct_last=0, done=0, busy=0.
  - ks_ready and pt_ready are combinational and read 0 in IDLE.
- Registered state: state, FIFO storage and pointers, drop_cnt[9:0], remaining[15:0], ct_valid/ct_data/ct_last, done.
- States: IDLE, DROP, RUN, DRAIN.
- IDLE:
  - ks_ready=0, pt_ready=0.
  - On start: FIFO flushed (pointers to 0), remaining<=msg_len, drop_cnt<=0.
  - Next state: msg_len==0 -> stay IDLE, done=1 on the next cycle. Else DROP if DROP_N>0, otherwise RUN.
- DROP:
  - ks_ready=1; accepted bytes are discarded, not written to the FIFO; drop_cnt increments per accepted byte.
  - When the DROP_N-th byte is accepted (drop_cnt==DROP_N-1 && handshake), go to RUN.
  - pt_ready=0.
- RUN, keystream side:
  - ks_ready = (ks_level != KS_DEPTH). Depends on the registered level only, never on a same-cycle pop.
  - Accepted byte is written at the write pointer; pointer wraps modulo KS_DEPTH.
- RUN, plaintext side:
  - pt_ready = (ks_level != 0) && (!ct_valid || ct_ready). Registered level only, so a byte pushed this cycle is not poppable until the next cycle.
  - On pt handshake: ct_data <= pt_data ^ fifo[rd_ptr]; ct_valid <= 1; ct_last <= (remaining==1); FIFO pop; remaining--.
  - If remaining==1, go to DRAIN.
  - Latency from pt handshake to ct_valid: 1 cycle.
- Output register, all states:
  - ct_valid clears on ct handshake unless reloaded by a new pt handshake in the same cycle.
  - ct_data and ct_last hold while ct_valid && !ct_ready.
- Simultaneous push and pop in one cycle: ks_level unchanged; both pointers advance.
- DRAIN:
  - ks_ready=0, pt_ready=0.
  - When the ct handshake of the ct_last byte occurs: done<=1 for one cycle, state<=IDLE.
  - Leftover FIFO bytes stay until the next start flushes them.
- start in any state other than IDLE is ignored; msg_len is not resampled.
- Width rules: XOR is bitwise 8-bit. remaining is 16-bit, so the maximum frame is 65535 bytes. No wrap can occur inside a frame.
- busy=1 in DROP/RUN/DRAIN; busy=0 in IDLE, including the cycle in which done is pulsed.

Test Plan:
1. Known-answer vector, DROP_N=0:
   - Stimulus: keystream EB 9F 77 81 B7 34 CA 72 A7 fed continuously; plaintext "Plaintext" (50 6C 61 69 6E 74 65 78 74); msg_len=9; ct_ready=1.
   - Response: ct = BB F3 16 E8 D9 40 AF 0A D3; ct_last only on D3; done one cycle after the D3 handshake.
2. Drop, DROP_N=3:
   - Stimulus: keystream 11 22 33 EB 9F.. ; same plaintext.
   - Response: first three bytes consumed with pt_ready=0; ct identical to scenario 1.
3. Backpressure:
   - Stimulus: ct_ready toggled 1,0,0,1 pattern; keystream never stalled.
   - Response: ct_data/ct_last stable while stalled; ks_level saturates at KS_DEPTH with ks_ready=0; no byte lost or duplicated.
4. Starved keystream:
   - Stimulus: ks_valid one cycle in four, pt_valid held 1.
   - Response: pt_ready high only when ks_level>0; output still matches vector; ks_level never negative.
5. Zero-length and ignored start:
   - Stimulus: start with msg_len=0; then start again mid-RUN.
   - Response: done pulses one cycle after the first start with busy=0 and no ct_valid; the mid-RUN start has no effect.
6. Reset mid-frame:
   - Stimulus: rst_n=0 after 4 ct bytes, then a new frame.
   - Response: all outputs 0 and ks_level=0 the cycle after reset; new frame output is correct from its first byte.

Source files
------------

// File: rtl/rc4_xor_stream_if.sv
// Handshake bundle for the RC4 XOR stage.
// Carries keystream in, plaintext in and ciphertext out.
interface rc4_xor_stream_if;
    logic       ks_valid;
    logic [7:0] ks_data;
    logic       ks_ready;
    logic       pt_valid;
    logic [7:0] pt_data;
    logic       pt_ready;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic       ct_last;
    logic       ct_ready;

    modport master (
        output ks_valid, ks_data, pt_valid, pt_data, ct_ready,
        input  ks_ready, pt_ready, ct_valid, ct_data, ct_last
    );

    modport slave (
        input  ks_valid, ks_data, pt_valid, pt_data, ct_ready,
        output ks_ready, pt_ready, ct_valid, ct_data, ct_last
    );
endinterface

// File: rtl/rc4_xor_stream.sv
// RC4 keystream consumer: buffers keystream, optionally drops
// the first DROP_N bytes, XORs with plaintext into a framed stream.
module rc4_xor_stream #(
    parameter int KS_DEPTH = 8,
    parameter int DROP_N   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               msg_len,
    rc4_xor_stream_if.slave           bus,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(KS_DEPTH):0] ks_level
);
    localparam int AW = $clog2(KS_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL      = LW'(KS_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [9:0]    DROP_LAST = 10'((DROP_N > 0) ? DROP_N - 1 : 0);

    typedef enum logic [1:0] {IDLE, DROP, RUN, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [9:0]    drop_cnt_q, drop_cnt_d;
    logic [15:0]   rem_q, rem_d;
    logic          ct_valid_q, ct_valid_d;
    logic [7:0]    ct_data_q, ct_data_d;
    logic          ct_last_q, ct_last_d;
    logic          done_q, done_d;
    logic [7:0]    mem_q [KS_DEPTH];

    logic ks_ready_c, pt_ready_c;
    logic ks_hs, pt_hs, ct_hs;
    logic push, pop;

    // Readiness looks only at registered level, never same-cycle pops.
    always_comb begin
        ks_ready_c = 1'b0;
        pt_ready_c = 1'b0;
        unique case (state_q)
            DROP: ks_ready_c = 1'b1;
            RUN: begin
                ks_ready_c = (level_q != FULL);
                pt_ready_c = (level_q != '0) && (!ct_valid_q || bus.ct_ready);
            end
            default: ;
        endcase
    end

    assign ks_hs = bus.ks_valid && ks_ready_c;
    assign pt_hs = bus.pt_valid && pt_ready_c;
    assign ct_hs = ct_valid_q && bus.ct_ready;
    assign push  = ks_hs && (state_q == RUN);
    assign pop   = pt_hs;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;
        rem_d      = rem_q;
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        ct_last_d  = ct_last_q;
        done_d     = 1'b0;

        if (ct_hs) begin
            ct_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    level_d    = '0;
                    rem_d      = msg_len;
                    drop_cnt_d = '0;
                    if (msg_len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = (DROP_N > 0) ? DROP : RUN;
                    end
                end
            end
            DROP: begin
                if (ks_hs) begin
                    drop_cnt_d = drop_cnt_q + 10'd1;
                    if (drop_cnt_q == DROP_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    ct_data_d  = bus.pt_data ^ mem_q[rd_ptr_q];
                    ct_valid_d = 1'b1;
                    ct_last_d  = (rem_q == 16'd1);
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DRAIN;
                    end
                end
                if (push && !pop) begin
                    level_d = level_q + LVL_ONE;
                end else if (pop && !push) begin
                    level_d = level_q - LVL_ONE;
                end
            end
            DRAIN: begin
                if (ct_hs && ct_last_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            rem_q      <= '0;
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            ct_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            rem_q      <= rem_d;
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
            ct_last_q  <= ct_last_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= bus.ks_data;
        end
    end

    assign bus.ks_ready = ks_ready_c;
    assign bus.pt_ready = pt_ready_c;
    assign bus.ct_valid = ct_valid_q;
    assign bus.ct_data  = ct_data_q;
    assign bus.ct_last  = ct_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign ks_level     = level_q;
endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed bench for rc4_xor_stream: RC4 "Key"/"Plaintext" vector
// under drop, backpressure, starvation, zero length and reset.
module tb_rc4_xor_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_s, sel;
    logic [15:0] len_s;
    logic        ks_valid, pt_valid, ct_ready;
    logic [7:0]  ks_data, pt_data;

    rc4_xor_stream_if if0 ();
    rc4_xor_stream_if if1 ();

    logic       busy0, done0, busy1, done1;
    logic [3:0] lvl0, lvl1;

    assign if0.ks_valid = ks_valid;
    assign if0.ks_data  = ks_data;
    assign if0.pt_valid = pt_valid;
    assign if0.pt_data  = pt_data;
    assign if0.ct_ready = ct_ready;
    assign if1.ks_valid = ks_valid;
    assign if1.ks_data  = ks_data;
    assign if1.pt_valid = pt_valid;
    assign if1.pt_data  = pt_data;
    assign if1.ct_ready = ct_ready;

    rc4_xor_stream #(.KS_DEPTH(8), .DROP_N(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s && !sel), .msg_len(len_s),
        .bus(if0), .busy(busy0), .done(done0), .ks_level(lvl0)
    );

    rc4_xor_stream #(.KS_DEPTH(8), .DROP_N(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s && sel), .msg_len(len_s),
        .bus(if1), .busy(busy1), .done(done1), .ks_level(lvl1)
    );

    wire       ks_rdy = sel ? if1.ks_ready : if0.ks_ready;
    wire       pt_rdy = sel ? if1.pt_ready : if0.pt_ready;
    wire       ct_vld = sel ? if1.ct_valid : if0.ct_valid;
    wire [7:0] ct_dat = sel ? if1.ct_data  : if0.ct_data;
    wire       ct_lst = sel ? if1.ct_last  : if0.ct_last;
    wire       busy   = sel ? busy1 : busy0;
    wire       done   = sel ? done1 : done0;
    wire [3:0] lvl    = sel ? lvl1 : lvl0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] ks_vec [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                               8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] pt_tab [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E,
                               8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] exp_tab [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                                8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ks_q [$];

    task automatic run_frame(input int len, input int ks_mode, input int ct_mode,
                             input int start_at, input int stop_after, input int drop);
        int ks_i = 0;
        int pt_i = 0;
        int ct_i = 0;
        int cyc  = 0;
        bit fin  = 1'b0;
        bit saw_full = 1'b0;
        @(negedge clk);
        start_s  = 1'b1;
        len_s    = 16'(len);
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        while (!fin) begin
            ks_valid = (ks_i < ks_q.size()) && (ks_mode == 0 || cyc % 4 == 0);
            ks_data  = ks_valid ? ks_q[ks_i] : 8'h00;
            pt_valid = (pt_i < len);
            pt_data  = pt_valid ? pt_tab[pt_i] : 8'h00;
            ct_ready = (ct_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            start_s  = (cyc == start_at);
            len_s    = start_s ? 16'd3 : 16'(len);
            #1;
            if (pt_rdy) check("pt_rdy_lvl", 32'(lvl != 0), 1);
            check("lvl_max", 32'(lvl <= 4'd8), 1);
            if (lvl == 4'd8) begin
                check("ks_rdy_full", 32'(ks_rdy), 0);
                saw_full = 1'b1;
            end
            if (ks_i < drop) check("drop_pt_rdy", 32'(pt_rdy), 0);
            check("busy_run", 32'(busy), 1);
            check("done_early", 32'(done), 0);
            if (ct_vld) begin
                check("ct_data", 32'(ct_dat), 32'(exp_tab[ct_i]));
                check("ct_last", 32'(ct_lst), 32'(ct_i == len - 1));
            end
            if (ks_valid && ks_rdy) ks_i++;
            if (pt_valid && pt_rdy) pt_i++;
            if (ct_vld && ct_ready) ct_i++;
            cyc++;
            if (ct_i == len || ct_i == stop_after) fin = 1'b1;
            if (cyc > 400) begin
                check("timeout", 32'(ct_i), 32'(len));
                fin = 1'b1;
            end
            @(negedge clk);
        end
        start_s  = 1'b0;
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        if (ct_i == len) begin
            #1;
            check("done", 32'(done), 1);
            check("busy_done", 32'(busy), 0);
            check("ct_vld_done", 32'(ct_vld), 0);
        end
        if (ct_mode != 0) check("saw_full", 32'(saw_full), 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ctv"}, 32'(ct_vld), 0);
        check({tag, "_ctd"}, 32'(ct_dat), 0);
        check({tag, "_ctl"}, 32'(ct_lst), 0);
        check({tag, "_lvl"}, 32'(lvl), 0);
        check({tag, "_ksr"}, 32'(ks_rdy), 0);
        check({tag, "_ptr"}, 32'(pt_rdy), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sel      = 1'b0;
        start_s  = 1'b0;
        len_s    = '0;
        ks_valid = 1'b0;
        ks_data  = '0;
        pt_valid = 1'b0;
        pt_data  = '0;
        ct_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle("rst");
        rst_n = 1'b1;

        ks_q = {};
        foreach (ks_vec[i]) ks_q.push_back(ks_vec[i]);
        run_frame(9, 0, 0, -1, -1, 0);

        sel  = 1'b1;
        ks_q = {8'h11, 8'h22, 8'h33};
        foreach (ks_vec[i]) ks_q.push_back(ks_vec[i]);
        run_frame(9, 0, 0, -1, -1, 3);
        sel  = 1'b0;

        ks_q = {};
        foreach (ks_vec[i]) ks_q.push_back(ks_vec[i]);
        for (int i = 0; i < 11; i++) ks_q.push_back(8'(8'h5A + i));
        run_frame(9, 0, 1, -1, -1, 0);

        ks_q = {};
        foreach (ks_vec[i]) ks_q.push_back(ks_vec[i]);
        run_frame(9, 1, 0, -1, -1, 0);

        @(negedge clk);
        start_s = 1'b1;
        len_s   = 16'd0;
        @(negedge clk);
        start_s = 1'b0;
        #1;
        check("zl_done", 32'(done), 1);
        check("zl_busy", 32'(busy), 0);
        check("zl_ctv", 32'(ct_vld), 0);
        @(negedge clk);
        #1;
        check("zl_done_clr", 32'(done), 0);

        run_frame(9, 0, 0, 3, -1, 0);

        run_frame(9, 0, 0, -1, 4, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_idle("mid_rst");
        rst_n = 1'b1;
        run_frame(9, 0, 0, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
